// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Writes a 32-bit immediate into the bit fields of an instruction
//               template (inverse of the immediate extender). Flags immediates
//               the format cannot represent. 2-stage valid/ready pipeline.
//               Optional round-trip self-check: IMM_ENC_SELFCHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_tmpl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_range_err,
    input  logic                 clr_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef IMM_ENC_SELFCHECK_EN
    ,
    output logic                 selfchk_fail
`endif
);

    localparam logic [2:0] c_OP_STYPE  = 3'b001;
    localparam logic [2:0] c_OP_ITYPE  = 3'b010;
    localparam logic [2:0] c_OP_ISHAMT = 3'b011;
    localparam logic [2:0] c_OP_BTYPE  = 3'b100;
    localparam logic [2:0] c_OP_UTYPE  = 3'b101;

    logic                 r_s1_valid;
    logic [2:0]           r_s1_op;
    logic [31:0]          r_s1_imm;
    logic [31:0]          r_s1_tmpl;
    logic                 r_s1_err;
    logic                 r_s2_valid;
    logic [31:0]          r_s2_instr;
    logic                 r_s2_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_s2_load;
    logic                 w_s1_adv;
    logic                 w_in_err;
    logic [31:0]          w_merged;
    logic                 w_retire;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_retire  = r_s2_valid && out_ready;

    assign out_valid     = r_s2_valid;
    assign out_instr     = r_s2_instr;
    assign out_range_err = r_s2_err;
    assign err_cnt       = r_err_cnt;

    // Range check on the incoming immediate; registered in stage 1.
    always_comb begin
        w_in_err = 1'b1;
        case (in_op)
            c_OP_ISHAMT: w_in_err = |in_imm[31:5];
            c_OP_ITYPE,
            c_OP_STYPE:  w_in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            c_OP_BTYPE:  w_in_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
            c_OP_UTYPE:  w_in_err = |in_imm[11:0];
            default:     w_in_err = 1'b1;
        endcase
    end

    // Field merge from stage-1 registers; out-of-range values are truncated.
    always_comb begin
        w_merged = r_s1_tmpl;
        case (r_s1_op)
            c_OP_ISHAMT: w_merged[24:20] = r_s1_imm[4:0];
            c_OP_ITYPE:  w_merged[31:20] = r_s1_imm[11:0];
            c_OP_STYPE: begin
                w_merged[31:25] = r_s1_imm[11:5];
                w_merged[11:7]  = r_s1_imm[4:0];
            end
            c_OP_BTYPE: begin
                w_merged[31]    = r_s1_imm[12];
                w_merged[7]     = r_s1_imm[11];
                w_merged[30:25] = r_s1_imm[10:5];
                w_merged[11:8]  = r_s1_imm[4:1];
            end
            c_OP_UTYPE:  w_merged[31:12] = r_s1_imm[31:12];
            default:     w_merged = r_s1_tmpl;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_imm   <= '0;
            r_s1_tmpl  <= '0;
            r_s1_err   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op   <= in_op;
                r_s1_imm  <= in_imm;
                r_s1_tmpl <= in_tmpl;
                r_s1_err  <= w_in_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= w_merged;
                r_s2_err   <= r_s1_err;
            end
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_retire && r_s2_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

`ifdef IMM_ENC_SELFCHECK_EN
    logic [2:0]  r_s2_op;
    logic [31:0] r_s2_imm;
    logic [31:0] w_reext;
    logic        w_chk_bad;
    logic        r_selfchk_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_op  <= '0;
            r_s2_imm <= '0;
        end else if (w_s2_load && r_s1_valid) begin
            r_s2_op  <= r_s1_op;
            r_s2_imm <= r_s1_imm;
        end
    end

    // Extender rules applied to the produced instruction.
    always_comb begin
        w_reext = '0;
        case (r_s2_op)
            c_OP_ISHAMT: w_reext = {27'b0, r_s2_instr[24:20]};
            c_OP_ITYPE:  w_reext = {{20{r_s2_instr[31]}}, r_s2_instr[31:20]};
            c_OP_STYPE:  w_reext = {{20{r_s2_instr[31]}}, r_s2_instr[31:25], r_s2_instr[11:7]};
            c_OP_BTYPE:  w_reext = {{19{r_s2_instr[31]}}, r_s2_instr[31], r_s2_instr[7],
                                    r_s2_instr[30:25], r_s2_instr[11:8], 1'b0};
            c_OP_UTYPE:  w_reext = {r_s2_instr[31:12], 12'b0};
            default:     w_reext = '0;
        endcase
    end

    assign w_chk_bad = w_retire && !r_s2_err && (w_reext != r_s2_imm);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_selfchk_fail <= 1'b0;
        end else begin
            r_selfchk_fail <= w_chk_bad;
        end
    end

    assign selfchk_fail = r_selfchk_fail;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_chk_bad) begin
            $error("imm_encoder round-trip: op=%0d imm=%08h reext=%08h", r_s2_op, r_s2_imm, w_reext);
        end
    end
`endif
`endif

endmodule
`default_nettype wire
